alu_issue_sequencer: RTL and testbench
======================================

Name: alu_issue_sequencer

Overview:
- Upstream control stage for the 4-bit registered ALU (add/sub/mul/div, opcodes 0001–0100, result registered one clock after operands are sampled).
- Accepts 12-bit instructions over a valid/ready handshake and reads operands from an internal 4x4-bit register file.
- Drives the ALU's opcode and operand inputs, captures the registered result and writes it back.
- Handles opcodes the ALU cannot: NOP, load-immediate, divide-by-zero, illegal.

Parameters:
- DIV0_VALUE, 4'hF, value written to rd on divide by zero; the divide is never issued to the ALU.
- ERR_STICKY, 1, 1: err holds until reset; 0: err pulses one cycle per faulting instruction.

Ports:
- clock  in  1  rising-edge clock, shared with the ALU.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  12  [11:8] op, [7:6] rd, [5:4] ra, [3:2] rb; LDI immediate = [3:0].
- alu_opcode  out  4  to ALU opcode.
- alu_ain  out  4  to ALU ain.
- alu_bin  out  4  to ALU bin.
- alu_result  in  4  from ALU out.
- wb_valid  out  1  one-cycle pulse when a register write occurs.
- wb_rd  out  2  register written.
- wb_data  out  4  value written.
- err  out  1  illegal opcode or divide by zero seen.
- dbg_addr  in  2  debug register-file read address.
- dbg_data  out  4  rf[dbg_addr], combinational.

Behaviour:
- Reset values:
  - state IDLE; all 4 registers 0.
  - in_ready 1; alu_opcode 0000; alu_ain, alu_bin 0.
  - wb_valid 0, wb_rd 0, wb_data 0, err 0.
- Opcodes:
  - 0000 NOP: no write.
  - 0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV: issued to the ALU.
  - 0101 LDI: rd <= imm.
  - 0110–1111: illegal.
- Handshake:
  - Transfer when in_valid & in_ready at a rising edge; the instruction is latched into IR.
  - in_ready = (state == IDLE), registered-state decode only, no combinational path from in_valid.
  - in_instr is ignored when not transferring.
- FSM (states IDLE, ISSUE, WB, LOCAL):
  - IDLE, on transfer:
    - op 0001–0100 with a nonzero divisor -> ISSUE.
    - All other ops -> LOCAL.
    - DIV with rf[rb] == 0 -> LOCAL (checked against the register value at transfer).
  - ISSUE (1 cycle):
    - alu_opcode = IR.op, alu_ain = rf[ra], alu_bin = rf[rb].
    - The ALU samples these at the end of ISSUE. Next state WB.
  - WB (1 cycle):
    - alu_opcode = 0000, so the ALU holds its output.
    - At the end of WB: rf[rd] <= alu_result; wb_valid = 1 for the following cycle with wb_rd/wb_data. Next state IDLE.
  - LOCAL (1 cycle):
    - LDI: rf[rd] <= imm, wb pulse.
    - DIV0: rf[rd] <= DIV0_VALUE, wb pulse, err set.
    - Illegal: no write, err set.
    - NOP: nothing.
    - Next state IDLE.
- Outside ISSUE, alu_opcode = 0000 and alu_ain/alu_bin = 0.
- Latency: ALU op = 3 cycles transfer-to-wb_valid; local op = 2. Throughput: one ALU op per 3 cycles.
- Arithmetic: the ALU's 4-bit truncation is accepted as-is; SUB wraps mod 16, MUL keeps the low 4 bits.
- Hazards:
  - Operands are read in ISSUE, after any prior write has completed, because a new transfer only occurs in IDLE.
  - rd == ra or rd == rb is legal and uses the old values.
- Registers: r0 is a normal writable register. dbg_data reflects a write the cycle after the write edge.
- Reset mid-operation: the instruction is abandoned with no write and the FSM returns to IDLE. The ALU has no reset; its stale output is ignored because alu_result is sampled only in WB.
- err: ERR_STICKY=1 holds until reset; ERR_STICKY=0 gives a 1-cycle pulse aligned with the wb slot.

Test Plan:
- Reset, then LDI r1=3 and LDI r2=7, each -> wb_valid pulse 2 cycles after transfer; dbg_data(r1)=3, dbg_data(r2)=7.
- ADD r3=r1+r2 -> alu_opcode=0001, ain=3, bin=7 in ISSUE; wb_data=A after 3 cycles; MUL r0=r1*r2 -> wb_data=5 (21 truncated).
- SUB r3=r1-r2 -> wb_data=C (3-7 wrap); DIV r3=r2/r1 -> 2; in_ready low for exactly 2 cycles after each ALU transfer.
- DIV by r-register holding 0 -> alu_opcode stays 0000 throughout, wb_data=F, err=1 and held; op 1010 -> no wb pulse, registers unchanged.
- Back-to-back in_valid held high with 4 ALU instructions -> transfers exactly every 3 cycles, in order, with correct chained results (r1=r1+r1 four times from 3 -> 6, C, 8, 0).
- Assert reset during ISSUE of ADD -> no wb pulse, all registers 0, in_ready=1 immediately after reset asserts.

Source files
------------

// File: rtl/alu_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_sequencer
// Issue/writeback sequencer driving a registered 4-bit ALU from a 4x4 reg file.
// Rev    : 1.0
// ============================================================================
module alu_issue_sequencer #(
  parameter logic [3:0]  DIV0_VALUE = 4'hF,
  parameter int unsigned ERR_STICKY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_instr,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_ain,
  output logic [3:0]  alu_bin,
  input  logic [3:0]  alu_result,
  output logic        wb_valid,
  output logic [1:0]  wb_rd,
  output logic [3:0]  wb_data,
  output logic        err,
  input  logic [1:0]  dbg_addr,
  output logic [3:0]  dbg_data
);

  localparam logic [3:0] c_OP_NOP = 4'h0;
  localparam logic [3:0] c_OP_ADD = 4'h1;
  localparam logic [3:0] c_OP_DIV = 4'h4;
  localparam logic [3:0] c_OP_LDI = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2,
    ST_LOCAL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] ir_q, ir_d;
  logic [3:0]  rf_q [4];
  logic        wb_valid_q;
  logic [1:0]  wb_rd_q;
  logic [3:0]  wb_data_q;
  logic        err_q;

  logic        w_rf_we;
  logic [3:0]  w_rf_wd;
  logic        w_err_set;

  logic [3:0]  w_in_op;
  logic [1:0]  w_in_rb;
  logic        w_in_is_alu;
  logic        w_in_div0;

  logic [3:0]  w_ir_op;
  logic [1:0]  w_ir_rd;
  logic [1:0]  w_ir_ra;
  logic [1:0]  w_ir_rb;
  logic [3:0]  w_ir_imm;

  assign w_in_op     = in_instr[11:8];
  assign w_in_rb     = in_instr[3:2];
  assign w_in_is_alu = (w_in_op >= c_OP_ADD) && (w_in_op <= c_OP_DIV);
  // Divisor checked against the register value present at transfer time.
  assign w_in_div0   = (w_in_op == c_OP_DIV) && (rf_q[w_in_rb] == 4'h0);

  assign w_ir_op  = ir_q[11:8];
  assign w_ir_rd  = ir_q[7:6];
  assign w_ir_ra  = ir_q[5:4];
  assign w_ir_rb  = ir_q[3:2];
  assign w_ir_imm = ir_q[3:0];

  assign in_ready = (state_q == ST_IDLE);
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign err      = err_q;
  assign dbg_data = rf_q[dbg_addr];

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    alu_opcode = c_OP_NOP;
    alu_ain    = 4'h0;
    alu_bin    = 4'h0;
    w_rf_we    = 1'b0;
    w_rf_wd    = 4'h0;
    w_err_set  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ir_d    = in_instr;
          state_d = (w_in_is_alu && !w_in_div0) ? ST_ISSUE : ST_LOCAL;
        end
      end

      ST_ISSUE: begin
        alu_opcode = w_ir_op;
        alu_ain    = rf_q[w_ir_ra];
        alu_bin    = rf_q[w_ir_rb];
        state_d    = ST_WB;
      end

      // Opcode is NOP here so the ALU holds the result being written back.
      ST_WB: begin
        w_rf_we = 1'b1;
        w_rf_wd = alu_result;
        state_d = ST_IDLE;
      end

      ST_LOCAL: begin
        if (w_ir_op == c_OP_LDI) begin
          w_rf_we = 1'b1;
          w_rf_wd = w_ir_imm;
        end else if (w_ir_op == c_OP_DIV) begin
          w_rf_we   = 1'b1;
          w_rf_wd   = DIV0_VALUE;
          w_err_set = 1'b1;
        end else if (w_ir_op > c_OP_LDI) begin
          w_err_set = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ir_q       <= 12'h000;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 2'd0;
      wb_data_q  <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= 4'h0;
      end
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      wb_valid_q <= w_rf_we;
      if (w_rf_we) begin
        rf_q[w_ir_rd] <= w_rf_wd;
        wb_rd_q       <= w_ir_rd;
        wb_data_q     <= w_rf_wd;
      end
    end
  end

  generate
    if (ERR_STICKY != 0) begin : g_err_sticky
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          err_q <= 1'b0;
        end else if (w_err_set) begin
          err_q <= 1'b1;
        end
      end
    end else begin : g_err_pulse
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          err_q <= 1'b0;
        end else begin
          err_q <= w_err_set;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_issue_sequencer
// Directed + randomized bench with a transaction-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_alu_issue_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_instr = 12'h000;
  logic [3:0]  alu_opcode;
  logic [3:0]  alu_ain;
  logic [3:0]  alu_bin;
  logic [3:0]  alu_result = 4'h9;
  logic        wb_valid;
  logic [1:0]  wb_rd;
  logic [3:0]  wb_data;
  logic        err;
  logic [1:0]  dbg_addr = 2'd0;
  logic [3:0]  dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_rf [4];
  logic       m_err;

  alu_issue_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_opcode (alu_opcode),
    .alu_ain    (alu_ain),
    .alu_bin    (alu_bin),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .err        (err),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #10 clock = ~clock;

  // Registered 4-bit ALU without reset; holds its output on opcode 0000.
  always @(posedge clock) begin
    case (alu_opcode)
      4'd1: alu_result <= alu_ain + alu_bin;
      4'd2: alu_result <= alu_ain - alu_bin;
      4'd3: alu_result <= alu_ain * alu_bin;
      4'd4: alu_result <= (alu_bin != 4'h0) ? alu_ain / alu_bin : 4'hF;
      default: ;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dbg_check();
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check($sformatf("dbg_r%0d", i), dbg_data, m_rf[i]);
    end
  endtask

  function automatic logic [11:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 2'b00};
  endfunction

  function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {4'h5, rd, 2'b00, imm};
  endfunction

  // One instruction from an idle sequencer; expectations come from the model.
  task automatic do_instr(input logic [11:0] ins);
    logic [3:0] op, a, b, res;
    logic [1:0] rd, ra, rb;
    bit         div0, alu_path, fault, writes;
    int         lat;
    op = ins[11:8]; rd = ins[7:6]; ra = ins[5:4]; rb = ins[3:2];
    a = m_rf[ra]; b = m_rf[rb];
    div0     = (op == 4'd4) && (b == 4'd0);
    alu_path = (op >= 4'd1) && (op <= 4'd4) && !div0;
    fault    = div0 || (op >= 4'd6);
    writes   = alu_path || div0 || (op == 4'd5);
    case (op)
      4'd1:    res = 4'(a + b);
      4'd2:    res = 4'(a - b);
      4'd3:    res = 4'(a * b);
      4'd4:    res = div0 ? 4'hF : a / b;
      4'd5:    res = ins[3:0];
      default: res = 4'h0;
    endcase
    lat = alu_path ? 3 : 2;

    @(negedge clock);
    check("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_instr = ins;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      if (k == 1) begin
        in_valid = 1'($urandom_range(0, 1));
        in_instr = 12'($urandom);
      end
      check("alu_opcode", alu_opcode, (k == 1 && alu_path) ? 32'(op) : 32'd0);
      check("alu_ain",    alu_ain,    (k == 1 && alu_path) ? 32'(a)  : 32'd0);
      check("alu_bin",    alu_bin,    (k == 1 && alu_path) ? 32'(b)  : 32'd0);
      check("in_ready",   in_ready,   (k == lat) ? 32'd1 : 32'd0);
      check("wb_valid",   wb_valid,   (k == lat && writes) ? 32'd1 : 32'd0);
      if (k == lat && writes) begin
        check("wb_rd",   wb_rd,   rd);
        check("wb_data", wb_data, res);
      end
      check("err", err, (k == lat) ? 32'(m_err | fault) : 32'(m_err));
      if (k == lat) in_valid = 1'b0;
    end
    if (fault)  m_err = 1'b1;
    if (writes) m_rf[rd] = res;
  endtask

  logic [3:0] e_b2b [4];
  int         idx, nwb, last;

  initial begin
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    m_err = 1'b0;

    // Reset values, checked both during and after reset.
    repeat (2) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_alu_ain", alu_ain, 0);
    check("rst_alu_bin", alu_bin, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_wb_valid", wb_valid, 0);
    dbg_check();

    do_instr(ldi(2'd1, 4'd3));
    do_instr(ldi(2'd2, 4'd7));
    dbg_check();
    do_instr(mk(4'd1, 2'd3, 2'd1, 2'd2));   // ADD r3 = 3+7 = A
    do_instr(mk(4'd3, 2'd0, 2'd1, 2'd2));   // MUL r0 = 21 -> 5
    do_instr(mk(4'd2, 2'd3, 2'd1, 2'd2));   // SUB r3 = 3-7 -> C
    do_instr(mk(4'd4, 2'd3, 2'd2, 2'd1));   // DIV r3 = 7/3 = 2
    dbg_check();
    do_instr(ldi(2'd0, 4'd0));
    do_instr(mk(4'd4, 2'd3, 2'd2, 2'd0));   // DIV by zero -> F, err
    do_instr(mk(4'hA, 2'd1, 2'd2, 2'd3));   // illegal
    do_instr(mk(4'd0, 2'd2, 2'd1, 2'd1));   // NOP
    dbg_check();
    do_instr(mk(4'd1, 2'd2, 2'd2, 2'd2));   // rd == ra == rb uses old values
    do_instr(ldi(2'd1, 4'd3));

    // Back-to-back: r1 = r1 + r1 four times with in_valid held high.
    for (int i = 0; i < 4; i++) begin
      m_rf[1] = 4'(m_rf[1] + m_rf[1]);
      e_b2b[i] = m_rf[1];
    end
    idx = 0; nwb = 0; last = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clock);
      if (wb_valid) begin
        check("b2b_wb_rd", wb_rd, 1);
        if (nwb < 4) check("b2b_wb_data", wb_data, e_b2b[nwb]);
        nwb++;
      end
      if (in_ready) begin
        if (idx < 4) begin
          if (idx > 0) check("b2b_gap", 32'(cyc - last), 3);
          last     = cyc;
          in_valid = 1'b1;
          in_instr = mk(4'd1, 2'd1, 2'd1, 2'd1);
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("b2b_transfers", idx, 4);
    check("b2b_wb_count", nwb, 4);
    dbg_check();

    // Randomized instruction mix with idle gaps and junk on in_instr.
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [3:0] op;
      sel = $urandom_range(0, 9);
      if (sel <= 5)      op = 4'($urandom_range(1, 4));
      else if (sel == 6) op = 4'd5;
      else if (sel == 7) op = 4'd0;
      else if (sel == 8) op = 4'($urandom_range(6, 15));
      else               op = 4'd4;
      if (op == 4'd5) do_instr(ldi(2'($urandom), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom)));
      else            do_instr(mk(op, 2'($urandom), 2'($urandom), 2'($urandom)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        in_instr = 12'($urandom);
        check("gap_wb_valid", wb_valid, 0);
        check("gap_in_ready", in_ready, 1);
      end
    end
    dbg_check();

    // Reset asserted during ISSUE of an ADD abandons it.
    do_instr(ldi(2'd1, 4'd4));
    do_instr(ldi(2'd2, 4'd5));
    @(negedge clock);
    in_valid = 1'b1;
    in_instr = mk(4'd1, 2'd3, 2'd1, 2'd2);
    @(negedge clock);
    check("mid_issue_opcode", alu_opcode, 1);
    in_valid = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    m_err = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_opcode", alu_opcode, 0);
    check("mid_rst_err", err, 0);
    dbg_check();
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("after_rst_wb_valid", wb_valid, 0);
      check("after_rst_in_ready", in_ready, 1);
    end
    dbg_check();
    do_instr(ldi(2'd3, 4'd9));
    dbg_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
